fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline and the initiator side of the instruction-memory interface. Holds the program counter, drives the word-aligned fetch address to the combinational instruction memory and captures the returned instruction into the IF/ID pipeline register. Handles stalls, decode flushes and branch/jump redirects, including a redirect that arrives while the stage is stalled.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/fetch_unit_pc_reg.sv | 59 +++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RISC-V pipeline front end.
//   NOP_INSTR      - canonical addi x0,x0,0 used to fill pipeline bubbles
//   fetch_state_t  - fetch-stage sequencing states
//   if_id_t        - IF/ID pipeline register contents
//   BUBBLE         - IF/ID value representing "no instruction"
//   align_word()   - clears the byte offset of an address
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter, pending-redirect target and misalignment flag.
//   clk, rst         - clock, asynchronous active-low reset
//   state            - current fetch state from the fetch_unit FSM
//   stall_f          - hold request from the hazard unit
//   redirect_valid   - taken branch/jump from EX
//   redirect_pc      - redirect target (byte offset is discarded)
//   pc               - current program counter (drives imem_addr)
//   pc_plus4         - pc + 4, combinational
//   take             - a redirect (new or pending) is applied on this edge
//   misalign_err     - sticky flag, a redirect target had a byte offset
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  fetch_state_t state,
    input  logic         stall_f,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    output logic         take,
    output logic         misalign_err
);

    logic [31:0] pending;
    logic [31:0] pc_next;
    logic [31:0] pending_next;
    logic [31:0] target;
    logic        misalign_next;
    logic        boot;

    // A redirect arriving in the same cycle as the stall release wins over
    // the pending one, so the live target is chosen first.
    always_comb begin
        boot          = (state == BOOT);
        pc_plus4      = pc + 32'd4;
        take          = !boot && !stall_f && (redirect_valid || state == PEND);
        target        = redirect_valid ? align_word(redirect_pc) : pending;
        pc_next       = take ? target : (boot || stall_f) ? pc : pc_plus4;
        pending_next  = (!boot && stall_f && redirect_valid) ? align_word(redirect_pc) : pending;
        misalign_next = misalign_err || (!boot && redirect_valid && (redirect_pc[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            pending      <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_next;
            pending      <= pending_next;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage; drives instruction memory and fills IF/ID.
//   clk, rst        - clock, asynchronous active-low reset
//   imem_addr       - fetch address (the PC register itself)
//   imem_instr      - combinational instruction read data
//   stall_f         - hold PC and IF/ID
//   flush_d         - load a bubble into IF/ID
//   redirect_valid  - taken branch/jump from EX, target on redirect_pc
//   if_id_*         - registered instruction, its PC, PC+4 and valid bit
//   misalign_err    - sticky misaligned-redirect flag
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall_f,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        misalign_err
);

    fetch_state_t state;
    fetch_state_t state_next;
    if_id_t       if_id;
    if_id_t       if_id_next;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic         take;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .state         (state),
        .stall_f       (stall_f),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .take          (take),
        .misalign_err  (misalign_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            if_id <= BUBBLE;
        end else begin
            state <= state_next;
            if_id <= if_id_next;
        end
    end

    // Any applied redirect drops the wrong-path fetch, so it bubbles IF/ID
    // just like an explicit flush; both override the stall hold.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     state_next = (redirect_valid && stall_f) ? PEND : RUN;
            PEND:    state_next = stall_f ? PEND : RUN;
            default: state_next = BOOT;
        endcase
        if_id_next = (state == BOOT || take || flush_d) ? BUBBLE :
                     stall_f ? if_id :
                     '{instr: imem_instr, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
    end

    assign imem_addr      = pc;
    assign if_id_instr    = if_id.instr;
    assign if_id_pc       = if_id.pc;
    assign if_id_pc_plus4 = if_id.pc_plus4;
    assign if_id_valid    = if_id.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a cycle-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        misalign_err;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall_f       (stall_f),
        .flush_d       (flush_d),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    // Memory returns its own address plus 0x100.
    assign imem_instr = imem_addr + 32'h100;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_ptgt = 32'd0;
    logic        m_pend = 1'b0;
    logic        m_boot = 1'b1;
    logic        m_mis = 1'b0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_ipc = 32'd0;
    logic [31:0] m_ipc4 = 32'd0;
    logic        m_valid = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bubble();
        m_instr = NOP;
        m_ipc = 32'd0;
        m_ipc4 = 32'd0;
        m_valid = 1'b0;
    endtask

    // Drive one cycle of inputs at a falling edge, advance the model across
    // the coming rising edge, queue the expectation, return at next falling edge.
    task automatic step(input logic r, input logic s, input logic f, input logic v, input logic [31:0] t);
        logic        prev_rst;
        logic        vv;
        logic [31:0] old_pc;
        exp_t        e;
        prev_rst = rst;
        vv = v && !(r && m_boot);
        rst = r;
        stall_f = s;
        flush_d = f;
        redirect_valid = vv;
        redirect_pc = t;
        old_pc = m_pc;
        if (!r) begin
            m_pc = RESET_PC;
            m_boot = 1'b1;
            m_pend = 1'b0;
            m_ptgt = 32'd0;
            m_mis = 1'b0;
            bubble();
        end else if (m_boot) begin
            m_boot = 1'b0;
            bubble();
        end else begin
            if (vv && t[1:0] != 2'b00) m_mis = 1'b1;
            if (!s && (vv || m_pend)) begin
                m_pc = vv ? {t[31:2], 2'b00} : m_ptgt;
                m_pend = 1'b0;
                bubble();
            end else if (s) begin
                if (vv) begin
                    m_pend = 1'b1;
                    m_ptgt = {t[31:2], 2'b00};
                end
            end else begin
                m_instr = old_pc + 32'h100;
                m_ipc = old_pc;
                m_ipc4 = old_pc + 32'd4;
                m_valid = 1'b1;
                m_pc = old_pc + 32'd4;
            end
            if (f) bubble();
        end
        e.addr = m_pc;
        e.instr = m_instr;
        e.pc = m_ipc;
        e.pc4 = m_ipc4;
        e.valid = m_valid;
        e.mis = m_mis;
        q.push_back(e);
        if (prev_rst && !r) begin
            #1;
            cmp("async_rst_addr", imem_addr, RESET_PC);
            cmp("async_rst_valid", {31'd0, if_id_valid}, 32'd0);
            cmp("async_rst_misalign", {31'd0, misalign_err}, 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cmp("imem_addr", imem_addr, e.addr);
                cmp("if_id_instr", if_id_instr, e.instr);
                cmp("if_id_pc", if_id_pc, e.pc);
                cmp("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
                cmp("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
                cmp("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        logic        r;
        logic        s;
        logic        f;
        logic        v;
        logic [31:0] t;
        logic [31:0] rnd;
        @(negedge clk);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        cmp("reset_addr", imem_addr, RESET_PC);
        step(1, 0, 0, 0, 0);
        cmp("boot_bubble", {31'd0, if_id_valid}, 32'd0);
        step(1, 0, 0, 0, 0);
        cmp("first_instr", if_id_instr, 32'h100);
        step(1, 0, 0, 0, 0);
        cmp("second_instr", if_id_instr, 32'h104);
        step(1, 0, 0, 0, 0);
        cmp("third_pc", if_id_pc, 32'h8);
        step(1, 0, 0, 0, 0);
        cmp("pc_at_0x10", imem_addr, 32'h10);
        step(1, 0, 0, 1, 32'h40);
        cmp("redirect_addr", imem_addr, 32'h40);
        cmp("redirect_bubble", {31'd0, if_id_valid}, 32'd0);
        step(1, 0, 0, 0, 0);
        cmp("redirect_ifpc", if_id_pc, 32'h40);
        step(1, 0, 0, 1, 32'h20);
        step(1, 1, 0, 1, 32'h80);
        cmp("stall_hold1", imem_addr, 32'h20);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        cmp("stall_hold3", imem_addr, 32'h20);
        step(1, 0, 0, 0, 0);
        cmp("pending_applied", imem_addr, 32'h80);
        step(1, 1, 0, 1, 32'h80);
        step(1, 0, 0, 1, 32'hC0);
        cmp("new_redirect_wins", imem_addr, 32'hC0);
        step(1, 0, 0, 1, 32'h2C);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        cmp("flush_stall_valid", {31'd0, if_id_valid}, 32'd0);
        cmp("flush_stall_instr", if_id_instr, NOP);
        cmp("flush_stall_pc", imem_addr, 32'h30);
        step(1, 0, 0, 1, 32'h46);
        cmp("misalign_pc", imem_addr, 32'h44);
        cmp("misalign_set", {31'd0, misalign_err}, 32'd1);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        cmp("misalign_sticky", {31'd0, misalign_err}, 32'd1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        cmp("post_reset_ifpc", if_id_pc, RESET_PC);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(99) >= 2);
            s = ($urandom_range(99) < 30);
            f = ($urandom_range(99) < 10);
            v = ($urandom_range(99) < 15);
            rnd = $urandom();
            t = (rnd & 32'h0000_0FFC) | (($urandom_range(19) == 0) ? {30'd0, rnd[13:12]} : 32'd0);
            step(r, s, f, v, t);
        end
        step(1, 0, 0, 0, 0);
        cmp("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
